// File: rtl/sb_crd_pkg.sv
// rtl/sb_crd_pkg.sv - shared constants, channel FSM encoding and srcid decode for the credit return controller
package sb_crd_pkg;

    localparam logic [1:0] SRCID_PHY = 2'b10;
    localparam logic [1:0] SRCID_D2D = 2'b01;

    localparam int MAX_CH      = 8;
    localparam int MAX_SRCID_W = 4;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_PULSE = 2'd1,
        CH_GAP   = 2'd2
    } ch_state_e;

    // Table entries sit on a MAX_SRCID_W stride; only the low srcid_w bits are compared.
    function automatic logic [MAX_CH-1:0] srcid_onehot(
        input logic [MAX_SRCID_W-1:0]        srcid,
        input logic [MAX_CH*MAX_SRCID_W-1:0] tbl,
        input int                            num_ch,
        input int                            srcid_w
    );
        logic [MAX_CH-1:0]      oh;
        logic [MAX_SRCID_W-1:0] mask;
        logic [MAX_SRCID_W-1:0] ent;
        logic                   found;
        oh    = '0;
        mask  = '0;
        found = 1'b0;
        for (int b = 0; b < MAX_SRCID_W; b++) begin
            if (b < srcid_w) mask[b] = 1'b1;
        end
        for (int c = 0; c < MAX_CH; c++) begin
            ent = tbl[c*MAX_SRCID_W +: MAX_SRCID_W];
            if (!found && (c < num_ch) && (((ent ^ srcid) & mask) == '0)) begin
                oh[c] = 1'b1;
                found = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/sb_credit_return_ctrl_if.sv
// rtl/sb_credit_return_ctrl_if.sv - FIFO read-side inputs and credit outputs of the credit return controller
interface sb_credit_return_ctrl_if #(
    parameter int NUM_CH  = 2,
    parameter int SRCID_W = 2
);
    logic               i_tx_fifo_read_en;
    logic               i_pl_inband_pres;
    logic [SRCID_W-1:0] i_srcid;
    logic               i_word_is_filler;
    logic [NUM_CH-1:0]  o_crd;
    logic [NUM_CH-1:0]  o_pend_nz;
    logic               o_ovf;

    modport master (
        output i_tx_fifo_read_en, i_pl_inband_pres, i_srcid, i_word_is_filler,
        input  o_crd, o_pend_nz, o_ovf
    );

    modport slave (
        input  i_tx_fifo_read_en, i_pl_inband_pres, i_srcid, i_word_is_filler,
        output o_crd, o_pend_nz, o_ovf
    );
endinterface

// File: rtl/sb_crd_channel.sv
// rtl/sb_crd_channel.sv - per-channel word counter, pending credit counter and pulse spacing FSM
module sb_crd_channel
    import sb_crd_pkg::*;
#(
    parameter int MSG_WORDS = 2,
    parameter int CNT_W     = 4,
    parameter int CRD_GAP   = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_word,
    input  logic i_flush,
    output logic o_crd,
    output logic o_pend_nz,
    output logic o_ovf
);
    localparam int WC_W  = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
    localparam int GAP_W = $clog2(CRD_GAP + 1);

    ch_state_e          state_q, state_d;
    logic [WC_W-1:0]    wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   pend_q, pend_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               pend_nz_q, pend_nz_d;
    logic               ovf_q, ovf_d;
    logic               inc;
    logic               dec;

    always_comb begin
        wcnt_d = wcnt_q;
        inc    = 1'b0;
        if (i_word) begin
            if (wcnt_q == WC_W'(MSG_WORDS - 1)) begin
                wcnt_d = '0;
                inc    = 1'b1;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end

        // The credit returned this cycle is paid for at the end of the pulse.
        dec    = (state_q == CH_PULSE);
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (inc && !dec) begin
            if (&pend_q) ovf_d  = 1'b1;
            else         pend_d = pend_q + 1'b1;
        end else if (dec && !inc) begin
            pend_d = pend_q - 1'b1;
        end

        if (i_flush) begin
            wcnt_d = '0;
            pend_d = '0;
        end
        pend_nz_d = (pend_d != '0);

        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            CH_IDLE: begin
                if ((pend_q != '0) && !i_flush) state_d = CH_PULSE;
            end
            CH_PULSE: begin
                state_d = CH_GAP;
                gap_d   = GAP_W'(CRD_GAP - 1);
            end
            CH_GAP: begin
                if (gap_q == '0) state_d = CH_IDLE;
                else             gap_d   = gap_q - 1'b1;
            end
            default: state_d = CH_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= CH_IDLE;
            wcnt_q    <= '0;
            pend_q    <= '0;
            gap_q     <= '0;
            pend_nz_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            pend_q    <= pend_d;
            gap_q     <= gap_d;
            pend_nz_q <= pend_nz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_crd     = (state_q == CH_PULSE);
    assign o_pend_nz = pend_nz_q;
    assign o_ovf     = ovf_q;

endmodule

// File: rtl/sb_credit_return_ctrl.sv
// rtl/sb_credit_return_ctrl.sv - multi-channel sideband credit return: read edge detect, srcid attribution, per-channel credit engines
module sb_credit_return_ctrl
    import sb_crd_pkg::*;
#(
    parameter int                        NUM_CH    = 2,
    parameter int                        SRCID_W   = 2,
    parameter logic [NUM_CH*SRCID_W-1:0] CH_SRCID  = {SRCID_PHY, SRCID_D2D},
    parameter int                        FILLER_CH = 0,
    parameter int                        MSG_WORDS = 2,
    parameter int                        CNT_W     = 4,
    parameter int                        CRD_GAP   = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    sb_credit_return_ctrl_if.slave  bus
);
    logic                          rd_en_q, rd_en_d;
    logic                          rd_pulse_q, rd_pulse_d;
    logic [MAX_CH*MAX_SRCID_W-1:0] srcid_tbl;
    logic [MAX_CH-1:0]             match_oh;
    logic [NUM_CH-1:0]             word_oh;
    logic [NUM_CH-1:0]             crd;
    logic [NUM_CH-1:0]             pend_nz;
    logic [NUM_CH-1:0]             ch_ovf;
    logic                          unused_decode;

    // A read strobe held for several cycles still stands for a single word.
    always_comb begin
        rd_en_d    = bus.i_tx_fifo_read_en;
        rd_pulse_d = bus.i_tx_fifo_read_en & ~rd_en_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_en_q    <= 1'b0;
            rd_pulse_q <= 1'b0;
        end else begin
            rd_en_q    <= rd_en_d;
            rd_pulse_q <= rd_pulse_d;
        end
    end

    always_comb begin
        srcid_tbl = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            srcid_tbl[c*MAX_SRCID_W +: SRCID_W] = CH_SRCID[c*SRCID_W +: SRCID_W];
        end
    end

    assign match_oh      = srcid_onehot(MAX_SRCID_W'(bus.i_srcid), srcid_tbl, NUM_CH, SRCID_W);
    assign unused_decode = ^match_oh;

    always_comb begin
        word_oh = '0;
        if (rd_pulse_q && bus.i_pl_inband_pres) begin
            if (bus.i_word_is_filler) word_oh[FILLER_CH] = 1'b1;
            else                      word_oh = match_oh[NUM_CH-1:0];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sb_crd_channel #(
            .MSG_WORDS (MSG_WORDS),
            .CNT_W     (CNT_W),
            .CRD_GAP   (CRD_GAP)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_word    (word_oh[g]),
            .i_flush   (~bus.i_pl_inband_pres),
            .o_crd     (crd[g]),
            .o_pend_nz (pend_nz[g]),
            .o_ovf     (ch_ovf[g])
        );
    end

    assign bus.o_crd     = crd;
    assign bus.o_pend_nz = pend_nz;
    assign bus.o_ovf     = |ch_ovf;

endmodule
